// File: rtl/fp_norm_round128.sv
// Normalize, round (IEEE 754, five modes) and pack an FP128X significand into FP128.
// Four register stages that stall together whenever the output is held by back-pressure.
module fp_norm_round128 #(
    parameter int EMSB = 14,
    parameter int FMSB = 111,
    parameter int FX   = 227
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [2:0]           rm,
    input  logic [EMSB+FX+2:0]   i,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [EMSB+FMSB+2:0] o,
    output logic                 o_inexact,
    output logic                 o_overflow,
    output logic                 o_underflow
);
    localparam int EW  = EMSB + 1;
    localparam int FW  = FMSB + 1;
    localparam int SW  = FX + 1;
    localparam int UB  = FX - 1;           // unit bit of the significand
    localparam int GB  = UB - FW - 1;      // guard bit once normalized
    localparam int RW  = FW + 2;
    localparam int XW  = EW + 1;
    localparam int LZW = $clog2(SW + 1);
    localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RUP = 3'd2, RM_RDN = 3'd3, RM_RMM = 3'd4
    } rm_e;

    logic advance;
    assign advance = ~o_valid | o_ready;
    assign i_ready = advance;

    logic           sign_in, special, nan_d, inf_d, zero_d;
    logic [EMSB:0]  exp_in;
    logic [FX:0]    sig_in;
    logic [LZW-1:0] lz_d;
    rm_e            rm_d;

    assign sign_in = i[EMSB+FX+2];
    assign exp_in  = i[FX+1 +: EW];
    assign sig_in  = i[FX:0];
    assign special = &exp_in;
    assign nan_d   = special & (|sig_in[UB:0]);
    assign inf_d   = special & ~(|sig_in[UB:0]);
    assign zero_d  = ~special & ~(|sig_in);
    assign rm_d    = (rm > 3'd4) ? RM_RNE : rm_e'(rm);

    always_comb begin
        lz_d = LZW'(SW);
        for (int k = 0; k < SW; k++) begin
            if (sig_in[k]) lz_d = LZW'(FX - k);
        end
    end

    logic s1_v_q, s2_v_q, s3_v_q, s4_v_q;
    logic           s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [EMSB:0]  s1_exp_q;
    logic [FX:0]    s1_sig_q;
    logic [LZW-1:0] s1_lz_q;
    rm_e            s1_rm_q;

    logic          s1_special, sticky_d;
    logic [XW-1:0] eff_exp, lzm1, shamt, exp2_d;
    logic [UB:0]   norm_d;

    assign s1_special = s1_nan_q | s1_inf_q | s1_zero_q;

    // An exponent field of 0 carries the same scale as 1; left shifts stop at that floor.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eff_exp  = (s1_exp_q == '0) ? XW'(1) : {1'b0, s1_exp_q};
        lzm1     = XW'(s1_lz_q) - XW'(1);
        shamt    = '0;
        norm_d   = s1_sig_q[UB:0];
        sticky_d = 1'b0;
        exp2_d   = eff_exp;
        if (!s1_special && s1_sig_q[FX]) begin
            norm_d   = s1_sig_q[FX:1];
            sticky_d = s1_sig_q[0];
            exp2_d   = eff_exp + XW'(1);
        end else if (!s1_special) begin
            shamt  = (lzm1 < eff_exp - XW'(1)) ? lzm1 : eff_exp - XW'(1);
            norm_d = s1_sig_q[UB:0] << shamt;
            exp2_d = eff_exp - shamt;
        end
    end

    logic          s2_sign_q, s2_sticky_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic [XW-1:0] s2_exp_q;
    logic [UB:0]   s2_norm_q;
    rm_e           s2_rm_q;

    logic          s2_special, g_bit, r_bit, s_bit, inexact_d, inc;
    logic [RW-1:0] rnd_d;

    assign s2_special = s2_nan_q | s2_inf_q | s2_zero_q;

    always_comb begin
        g_bit     = s2_norm_q[GB];
        r_bit     = s2_norm_q[GB-1];
        s_bit     = (|s2_norm_q[GB-2:0]) | s2_sticky_q;
        inexact_d = ~s2_special & (g_bit | r_bit | s_bit);
        inc       = 1'b0;
        case (s2_rm_q)
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~s2_sign_q & inexact_d;
            RM_RDN:  inc = s2_sign_q & inexact_d;
            RM_RMM:  inc = g_bit;
            default: inc = g_bit & (r_bit | s_bit | s2_norm_q[GB+1]);
        endcase
        if (s2_special) inc = 1'b0;
        rnd_d = {1'b0, s2_norm_q[UB:GB+1]} + RW'(inc);
    end

    logic          s3_sign_q, s3_inexact_q, s3_tiny_q, s3_nan_q, s3_inf_q, s3_zero_q;
    logic [XW-1:0] s3_exp_q;
    logic [RW-1:0] s3_rnd_q;
    rm_e           s3_rm_q;

    logic [EMSB+FMSB+2:0] o_d;
    logic [XW-1:0]        e4;
    logic [FMSB:0]        frac4;
    logic                 to_inf, ovf_d, inexact4_d, unf_d;

    always_comb begin
        o_d        = '0;
        e4         = s3_exp_q;
        frac4      = s3_rnd_q[FMSB:0];
        ovf_d      = 1'b0;
        inexact4_d = 1'b0;
        unf_d      = 1'b0;
        to_inf     = (s3_rm_q == RM_RNE) || (s3_rm_q == RM_RMM) ||
                     (s3_rm_q == RM_RUP && !s3_sign_q) || (s3_rm_q == RM_RDN && s3_sign_q);
        if (s3_rnd_q[RW-1]) begin
            e4    = s3_exp_q + XW'(1);
            frac4 = '0;
        end else if (!s3_rnd_q[RW-2]) begin
            e4 = '0;
        end
        if (s3_nan_q) begin
            o_d = {s3_sign_q, {EW{1'b1}}, 1'b1, s3_rnd_q[FMSB:1]};
        end else if (s3_inf_q) begin
            o_d = {s3_sign_q, {EW{1'b1}}, {FW{1'b0}}};
        end else if (s3_zero_q) begin
            o_d = {s3_sign_q, {(EW + FW){1'b0}}};
        end else begin
            ovf_d      = (e4 >= EMAX);
            inexact4_d = s3_inexact_q | ovf_d;
            unf_d      = s3_tiny_q & s3_inexact_q;
            if (ovf_d && to_inf)
                o_d = {s3_sign_q, {EW{1'b1}}, {FW{1'b0}}};
            else if (ovf_d)
                o_d = {s3_sign_q, {EMSB{1'b1}}, 1'b0, {FW{1'b1}}};
            else
                o_d = {s3_sign_q, e4[EMSB:0], frac4};
        end
    end

    logic [EMSB+FMSB+2:0] out_q;
    logic                 inexact_q, overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            s4_v_q      <= 1'b0;
            out_q       <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (advance) begin
            s1_v_q <= i_valid;
            s2_v_q <= s1_v_q;
            s3_v_q <= s2_v_q;
            s4_v_q <= s3_v_q;
            if (s3_v_q) begin
                out_q       <= o_d;
                inexact_q   <= inexact4_d;
                overflow_q  <= ovf_d;
                underflow_q <= unf_d;
            end
        end
    end

    // NOTE: intermediate data is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_sign_q    <= sign_in;
            s1_exp_q     <= exp_in;
            s1_sig_q     <= sig_in;
            s1_nan_q     <= nan_d;
            s1_inf_q     <= inf_d;
            s1_zero_q    <= zero_d;
            s1_lz_q      <= lz_d;
            s1_rm_q      <= rm_d;
            s2_sign_q    <= s1_sign_q;
            s2_exp_q     <= exp2_d;
            s2_norm_q    <= norm_d;
            s2_sticky_q  <= sticky_d;
            s2_nan_q     <= s1_nan_q;
            s2_inf_q     <= s1_inf_q;
            s2_zero_q    <= s1_zero_q;
            s2_rm_q      <= s1_rm_q;
            s3_sign_q    <= s2_sign_q;
            s3_exp_q     <= s2_exp_q;
            s3_rnd_q     <= rnd_d;
            s3_inexact_q <= inexact_d;
            s3_tiny_q    <= ~s2_norm_q[UB];
            s3_nan_q     <= s2_nan_q;
            s3_inf_q     <= s2_inf_q;
            s3_zero_q    <= s2_zero_q;
            s3_rm_q      <= s2_rm_q;
        end
    end

    assign o_valid     = s4_v_q;
    assign o           = out_q;
    assign o_inexact   = inexact_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_fp_norm_round128.sv
// Randomized and directed bench for fp_norm_round128 against an exact-arithmetic rounding model.
module tb_fp_norm_round128;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         i_ready;
    logic [2:0]   rm_in;
    logic [243:0] din;
    logic         o_valid;
    logic         o_ready;
    logic [127:0] dout;
    logic         o_inexact, o_overflow, o_underflow;

    fp_norm_round128 dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .rm(rm_in), .i(din),
        .o_valid(o_valid), .o_ready(o_ready), .o(dout),
        .o_inexact(o_inexact), .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [130:0] res;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           rdy_mode = 0;   // 0 always ready, 1 scheduled 5-cycle stall, 2 random, 3 never
    int           stall_from = -100;
    bit           chk_lat = 1'b0;
    logic [130:0] cur_exp;

    task automatic check(input string tag, input logic [130:0] got, input logic [130:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [227:0] bit_at(input int n);
        logic [227:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Result = {o[127:0], inexact, overflow, underflow}, derived from the exact value sig * 2^(E-bias-226).
    function automatic logic [130:0] model(input logic s, input logic [14:0] ex,
                                           input logic [227:0] sg, input logic [2:0] m);
        logic [383:0] mm, f, rem, half, one;
        int           e, p, d, er, fe;
        logic         inex, inc, tiny, ovf, to_inf;
        one = 384'd1;
        if (ex == 15'h7fff) begin
            if (sg[226:0] != '0) return {s, 15'h7fff, 1'b1, sg[225:115], 3'b000};
            return {s, 15'h7fff, 112'd0, 3'b000};
        end
        if (sg == '0) return {s, 127'd0, 3'b000};
        e = (ex == 15'd0) ? 1 : int'(ex);
        p = 0;
        for (int k = 0; k < 228; k++) if (sg[k]) p = k;
        er = e + p - 226;
        if (er < 1) er = 1;
        d  = er - e + 114;
        mm = 384'(sg);
        if (d <= 0) begin
            f = mm << (-d); rem = '0; half = '0;
        end else begin
            f = mm >> d; rem = mm & ((one << d) - one); half = one << (d - 1);
        end
        tiny = f < (one << 112);
        inex = rem != '0;
        case (m)
            3'd1:    inc = 1'b0;
            3'd2:    inc = !s && inex;
            3'd3:    inc = s && inex;
            3'd4:    inc = inex && (rem >= half);
            default: inc = inex && ((rem > half) || (rem == half && f[0]));
        endcase
        f = f + 384'(inc);
        if (f >= (one << 113)) begin
            f = f >> 1;
            er++;
        end
        fe  = (f >= (one << 112)) ? er : 0;
        ovf = er >= 32767;
        if (ovf) begin
            to_inf = (m == 3'd0) || (m >= 3'd4) || (m == 3'd2 && !s) || (m == 3'd3 && s);
            if (to_inf) return {s, 15'h7fff, 112'd0, 3'b110};
            return {s, 15'h7ffe, {112{1'b1}}, 3'b110};
        end
        return {s, 15'(fe), f[111:0], inex, 1'b0, tiny && inex};
    endfunction

    // One clock: drive o_ready at the falling edge, sample 1 ns later, then cross the rising edge.
    task automatic step(output bit acc);
        case (rdy_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = !(cyc >= stall_from && cyc < stall_from + 5);
            2:       o_ready = ($urandom_range(0, 3) != 0);
            default: o_ready = 1'b0;
        endcase
        #1;
        check("i_ready", i_ready, !o_valid || o_ready);
        acc = i_valid && i_ready;
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("extra_out", o_valid, 1'b0);
            end else begin
                check("result", {dout, o_inexact, o_overflow, o_underflow}, sb[0].res);
                if (o_ready) begin
                    if (chk_lat) check("latency", 131'(cyc - sb[0].cyc), 131'd4);
                    void'(sb.pop_front());
                end
            end
        end
        if (acc) sb.push_back('{cur_exp, cyc});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic s, input logic [14:0] ex, input logic [227:0] sg,
                        input logic [2:0] m, input logic [130:0] want);
        bit acc;
        acc     = 1'b0;
        din     = {s, ex, sg};
        rm_in   = m;
        cur_exp = want;
        i_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            step(acc);
            if (acc) break;
        end
        if (!acc) check("capture", i_ready, 1'b1);
        i_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic         s;
        logic [14:0]  ex;
        logic [227:0] sg;
        logic [255:0] w;
        logic [2:0]   m;
        int           r, sh;
        s = 1'($urandom_range(0, 1));
        m = 3'($urandom_range(0, 7));
        r = int'($urandom_range(0, 19));
        if (r == 0)      ex = 15'd0;
        else if (r <= 2) ex = 15'($urandom_range(1, 4));
        else if (r <= 4) ex = 15'($urandom_range(32760, 32766));
        else if (r == 5) ex = 15'h7fff;
        else             ex = 15'($urandom_range(1, 32766));
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
        sg = w[227:0];
        if ($urandom_range(0, 2) != 0) sg[227] = 1'b0;
        sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 230)) : int'($urandom_range(0, 2));
        sg = sg >> sh;
        if ($urandom_range(0, 3) == 0) sg[111:0] = '0;
        if ($urandom_range(0, 7) == 0) sg[113:0] = {1'b1, 113'd0};
        if (ex == 15'd0 || ex == 15'h7fff) sg[227] = 1'b0;
        if (ex == 15'h7fff && $urandom_range(0, 1) == 1) sg = '0;
        send(s, ex, sg, m, model(s, ex, sg, m));
    endtask

    task automatic drain(input int budget);
        bit acc;
        i_valid = 1'b0;
        for (int t = 0; t < budget && sb.size() > 0; t++) step(acc);
        check("drain_empty", 131'(sb.size()), 131'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [227:0] ovf_sig;
        bit           acc;
        i_valid = 1'b0;
        rm_in   = 3'd0;
        din     = '0;
        o_ready = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_o_valid", o_valid, 1'b0);
        check("reset_o", {dout, o_inexact, o_overflow, o_underflow}, 131'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_o_valid", o_valid, 1'b0);
        check("post_reset_i_ready", i_ready, 1'b1);
        @(negedge clk);

        ovf_sig = '0;
        for (int k = 113; k <= 226; k++) ovf_sig[k] = 1'b1;

        // Directed cases streamed back to back with o_ready held high.
        chk_lat  = 1'b1;
        rdy_mode = 0;
        send(1'b0, 15'h3fff, bit_at(227), 3'd0, {1'b0, 15'h4000, 112'd0, 3'b000});
        send(1'b0, 15'h3fff, bit_at(224), 3'd0, {1'b0, 15'h3ffd, 112'd0, 3'b000});
        send(1'b0, 15'h3fff, bit_at(226) | bit_at(113), 3'd0, {1'b0, 15'h3fff, 112'd0, 3'b100});
        send(1'b0, 15'h3fff, bit_at(226) | bit_at(114) | bit_at(113), 3'd0,
             {1'b0, 15'h3fff, 112'd2, 3'b100});
        send(1'b0, 15'h3fff, bit_at(226) | bit_at(113), 3'd4, {1'b0, 15'h3fff, 112'd1, 3'b100});
        send(1'b0, 15'h7ffe, ovf_sig, 3'd0, {1'b0, 15'h7fff, 112'd0, 3'b110});
        send(1'b0, 15'h7ffe, ovf_sig, 3'd1, {1'b0, 15'h7ffe, {112{1'b1}}, 3'b100});
        send(1'b0, 15'h0001, bit_at(220), 3'd0, {1'b0, 15'h0000, 112'd1 << 106, 3'b000});
        send(1'b0, 15'h0001, bit_at(220) | bit_at(0), 3'd0, {1'b0, 15'h0000, 112'd1 << 106, 3'b101});
        send(1'b0, 15'h7fff, bit_at(200), 3'd0,
             {1'b0, 15'h7fff, (112'd1 << 111) | (112'd1 << 85), 3'b000});
        send(1'b1, 15'h7fff, 228'd0, 3'd2, {1'b1, 15'h7fff, 112'd0, 3'b000});
        send(1'b1, 15'h0000, 228'd0, 3'd3, {1'b1, 15'h0000, 112'd0, 3'b000});
        drain(50);
        chk_lat = 1'b0;

        // Five-cycle output stall in the middle of a stream.
        rdy_mode   = 1;
        stall_from = cyc + 6;
        for (int n = 0; n < 10; n++) send_rand();
        drain(100);

        // Random traffic with random back-pressure and input gaps.
        rdy_mode = 2;
        for (int n = 0; n < 400; n++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) step(acc);
        end
        drain(2000);

        // Reset while results are held in the pipeline.
        rdy_mode = 3;
        for (int n = 0; n < 3; n++) send_rand();
        for (int n = 0; n < 3; n++) step(acc);
        rst_n = 1'b0;
        #1;
        check("midrst_o_valid", o_valid, 1'b0);
        check("midrst_i_ready", i_ready, 1'b1);
        check("midrst_o", {dout, o_inexact, o_overflow, o_underflow}, 131'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        send(1'b0, 15'h3fff, bit_at(227), 3'd0, {1'b0, 15'h4000, 112'd0, 3'b000});
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
